// File: rtl/keypad_entry.sv
// keypad_entry: debounces the numeric keypad, buffers up to MAX_DIGITS BCD digits
// and streams them MSD-first into the timer's input_signal/load port on enter.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [9:0]              keypad,
  input  logic                    enter,
  input  logic                    cancel,
  output logic [3:0]              input_signal,
  output logic                    load,
  output logic [4*MAX_DIGITS-1:0] entry,
  output logic [2:0]              count,
  output logic                    busy
);

  // state | meaning
  // IDLE  | collecting digits, waiting for an enter edge
  // SEND  | strobing buffered digits to the timer, two cycles per digit
  typedef enum logic {IDLE, SEND} state_t;
  typedef enum logic {RELEASED, HELD} db_phase_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int EW = 4 * MAX_DIGITS;

  state_t          state_q, state_d;
  db_phase_t       phase_q, phase_d;
  logic [CW-1:0]   db_cnt_q, db_cnt_d;
  logic [9:0]      key_prev_q, key_prev_d;
  logic            enter_prev_q, enter_prev_d;
  logic            cancel_prev_q, cancel_prev_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [2:0]      count_q, count_d;
  logic [1:0]      idx_q, idx_d;
  logic            gap_q, gap_d;
  logic            load_q, load_d;
  logic [3:0]      digit_q, digit_d;

  logic            key_onehot;
  logic [3:0]      key_digit;
  logic [CW-1:0]   cnt_inc;
  logic            accept;
  logic            enter_rise;
  logic            cancel_rise;
  logic [EW-1:0]   entry_app;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= IDLE;
      phase_q       <= RELEASED;
      db_cnt_q      <= '0;
      key_prev_q    <= '0;
      enter_prev_q  <= 1'b0;
      cancel_prev_q <= 1'b0;
      entry_q       <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      gap_q         <= 1'b0;
      load_q        <= 1'b0;
      digit_q       <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      db_cnt_q      <= db_cnt_d;
      key_prev_q    <= key_prev_d;
      enter_prev_q  <= enter_prev_d;
      cancel_prev_q <= cancel_prev_d;
      entry_q       <= entry_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      load_q        <= load_d;
      digit_q       <= digit_d;
    end
  end

  always_comb begin
    key_onehot = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
    key_digit  = '0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_digit = 4'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    db_cnt_d      = db_cnt_q;
    key_prev_d    = keypad;
    enter_prev_d  = enter;
    cancel_prev_d = cancel;
    entry_d       = entry_q;
    count_d       = count_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    load_d        = 1'b0;
    digit_d       = digit_q;
    accept        = 1'b0;
    cnt_inc       = db_cnt_q + CW'(1);
    enter_rise    = enter & ~enter_prev_q;
    cancel_rise   = cancel & ~cancel_prev_q;
    entry_app     = (entry_q << 4) | EW'(key_digit);

    // Counter holds the length of the current run of identical valid samples.
    if (phase_q == RELEASED) begin
      if (!key_onehot) begin
        db_cnt_d = '0;
      end else if (keypad == key_prev_q && db_cnt_q != '0) begin
        db_cnt_d = cnt_inc;
      end else begin
        db_cnt_d = CW'(1);
      end
      if (db_cnt_d == CW'(DEBOUNCE_CYCLES)) begin
        accept   = 1'b1;
        phase_d  = HELD;
        db_cnt_d = '0;
      end
    end else begin
      if (keypad != '0) begin
        db_cnt_d = '0;
      end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
        phase_d  = RELEASED;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = cnt_inc;
      end
    end

    case (state_q)
      IDLE: begin
        if (cancel_rise) begin
          entry_d = '0;
          count_d = '0;
        end else begin
          if (accept && count_q < 3'(MAX_DIGITS)) begin
            entry_d = entry_app;
            count_d = count_q + 3'd1;
          end
          // A digit accepted on the enter edge is already part of this transfer.
          if (enter_rise && count_d != '0) begin
            state_d = SEND;
            idx_d   = 2'(MAX_DIGITS - 1);
            gap_d   = 1'b0;
            load_d  = 1'b1;
            digit_d = entry_d[4*(MAX_DIGITS-1) +: 4];
          end
        end
      end
      SEND: begin
        if (cancel_rise || (gap_q && idx_q == '0)) begin
          state_d = IDLE;
          entry_d = '0;
          count_d = '0;
          digit_d = '0;
          gap_d   = 1'b0;
          idx_d   = '0;
        end else if (!gap_q) begin
          gap_d = 1'b1;
        end else begin
          idx_d   = idx_q - 2'd1;
          gap_d   = 1'b0;
          load_d  = 1'b1;
          digit_d = entry_q[4*idx_d +: 4];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign input_signal = digit_q;
  assign load         = load_q;
  assign entry        = entry_q;
  assign count        = count_q;
  assign busy         = (state_q == SEND);

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus randomized
// keypad/enter/cancel traffic against a history-based behavioural model.
module tb_keypad_entry;
  localparam int D = 4;
  localparam int M = 3;

  logic          clk = 1'b0;
  logic          clear;
  logic [9:0]    keypad;
  logic          enter;
  logic          cancel;
  logic [3:0]    input_signal;
  logic          load;
  logic [4*M-1:0] entry;
  logic [2:0]    count;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  keypad_entry #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(M)) dut (
    .clk(clk), .clear(clear), .keypad(keypad), .enter(enter), .cancel(cancel),
    .input_signal(input_signal), .load(load), .entry(entry), .count(count), .busy(busy)
  );

  // Model: debouncing from the last D raw samples, buffer as a digit queue,
  // transfer as a list of digits indexed by elapsed cycles.
  logic [9:0] hist[$];
  bit         m_held;
  int         digits[$];
  int         xfer[$];
  bit         m_send;
  int         m_t;
  bit         en_p, ca_p;

  function automatic bit onehot(logic [9:0] v);
    return (v != 0) && ((v & (v - 10'd1)) == 0);
  endfunction

  function automatic int digit_of(logic [9:0] v);
    int d = 0;
    for (int i = 0; i < 10; i++) if (v[i]) d = i;
    return d;
  endfunction

  task automatic model_edge();
    bit acc, same, er, cr;
    int d;
    if (clear) begin
      hist.delete(); digits.delete(); xfer.delete();
      m_held = 0; m_send = 0; m_t = 0; en_p = 0; ca_p = 0;
      return;
    end
    er = enter && !en_p;
    cr = cancel && !ca_p;
    en_p = enter;
    ca_p = cancel;
    acc = 0;
    d = 0;
    hist.push_back(keypad);
    if (hist.size() > D) void'(hist.pop_front());
    if (hist.size() == D) begin
      same = 1;
      foreach (hist[i]) if (hist[i] !== hist[0]) same = 0;
      if (same && !m_held && onehot(hist[0])) begin
        acc = 1; d = digit_of(hist[0]); m_held = 1; hist.delete();
      end else if (same && m_held && hist[0] == 0) begin
        m_held = 0; hist.delete();
      end
    end
    if (!m_send) begin
      if (cr) digits.delete();
      else begin
        if (acc && digits.size() < M) digits.push_back(d);
        if (er && digits.size() > 0) begin
          xfer.delete();
          repeat (M - digits.size()) xfer.push_back(0);
          foreach (digits[i]) xfer.push_back(digits[i]);
          m_send = 1; m_t = 0;
        end
      end
    end else if (cr) begin
      m_send = 0; digits.delete();
    end else begin
      m_t++;
      if (m_t == 2 * M) begin m_send = 0; digits.delete(); end
    end
  endtask

  function automatic logic [4*M-1:0] m_entry();
    logic [4*M-1:0] e = '0;
    foreach (digits[i]) e = (e << 4) | (4*M)'(digits[i]);
    return e;
  endfunction

  function automatic logic [4*M+8:0] m_vec();
    logic [3:0] sig;
    sig = m_send ? 4'(xfer[m_t / 2]) : 4'd0;
    return {m_send && (m_t % 2 == 0), m_send, sig, 3'(digits.size()), m_entry()};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press(input int d);
    keypad = 10'(1) << d;
    repeat (D + 1) step();
    keypad = '0;
    repeat (D + 1) step();
  endtask

  task automatic test_reset();
    clear = 1; keypad = '0; enter = 0; cancel = 0;
    repeat (2) step();
    n_checks++; if (entry !== '0) $display("FAIL reset_entry: got %h want 0", entry); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (load !== 1'b0) $display("FAIL reset_load: got %b want 0", load); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (input_signal !== 4'd0) $display("FAIL reset_sig: got %h want 0", input_signal); else n_pass++;
    clear = 0;
    step();
  endtask

  task automatic test_debounce();
    logic [9:0] bounce[10] = '{10'd0, 10'h020, 10'd0, 10'd0, 10'h020, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
    for (int i = 0; i < 10; i++) begin keypad = (i % 2) ? 10'h020 : 10'h000; step(); end
    keypad = 10'h020;
    repeat (6) step();
    foreach (bounce[i]) begin keypad = bounce[i]; step(); end
    n_checks++; if (entry !== 12'h005) $display("FAIL debounce_entry: got %h want 005", entry); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL debounce_count: got %0d want 1", count); else n_pass++;
    keypad = 10'b0010000100;
    repeat (10) step();
    keypad = '0;
    repeat (D + 1) step();
    n_checks++; if (entry !== 12'h005 || entry !== m_entry())
      $display("FAIL multihot_entry: got %h want 005 model %h", entry, m_entry()); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL multihot_count: got %0d want 1", count); else n_pass++;
  endtask

  task automatic test_entry_overflow();
    cancel = 1; step(); cancel = 0; step();
    n_checks++; if (count !== 3'd0) $display("FAIL cancel_idle_count: got %0d want 0", count); else n_pass++;
    press(1); press(3); press(0); press(9);
    n_checks++; if (entry !== 12'h130) $display("FAIL overflow_entry: got %h want 130", entry); else n_pass++;
    n_checks++; if (count !== 3'd3) $display("FAIL overflow_count: got %0d want 3", count); else n_pass++;
  endtask

  task automatic run_transfer(input string name, input int want[$]);
    int got[$];
    enter = 1;
    step();
    enter = 0;
    for (int k = 0; k <= 2 * M; k++) begin
      n_checks++;
      if ({load, busy, input_signal, count, entry} !== m_vec())
        $display("FAIL %s_cycle%0d: got %h want %h", name, k, {load, busy, input_signal, count, entry}, m_vec());
      else n_pass++;
      if (load) got.push_back(int'(input_signal));
      if (k < 2 * M) step();
    end
    n_checks++;
    if (got != want) $display("FAIL %s_digits: got %p want %p", name, got, want); else n_pass++;
    n_checks++;
    if (busy !== 0 || entry !== '0 || count !== 3'd0)
      $display("FAIL %s_done: got busy %b entry %h count %0d want 0 0 0", name, busy, entry, count);
    else n_pass++;
  endtask

  task automatic test_transfer();
    run_transfer("transfer", '{1, 3, 0});
  endtask

  task automatic test_partial();
    press(7);
    run_transfer("partial", '{0, 0, 7});
  endtask

  task automatic test_cancel_mid();
    int off, loads;
    for (int rep = 0; rep < 5; rep++) begin
      off = (rep == 0) ? 2 : $urandom_range(1, 2 * M - 1);
      press($urandom_range(0, 9));
      enter = 1; step(); enter = 0;
      loads = load ? 1 : 0;
      repeat (off - 1) begin step(); if (load) loads++; end
      cancel = 1; step(); cancel = 0;
      n_checks++;
      if ({load, busy, input_signal, count, entry} !== '0)
        $display("FAIL cancel_mid_off%0d: got %h want 0", off, {load, busy, input_signal, count, entry});
      else n_pass++;
      n_checks++;
      if (loads != (off + 1) / 2) $display("FAIL cancel_mid_loads%0d: got %0d want %0d", off, loads, (off + 1) / 2);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_collision();
    press(4);
    enter = 1; cancel = 1; step(); enter = 0; cancel = 0;
    n_checks++;
    if (load !== 0 || busy !== 0 || entry !== '0 || count !== 3'd0)
      $display("FAIL cancel_enter: got load %b busy %b entry %h count %0d want 0", load, busy, entry, count);
    else n_pass++;
    step();
    keypad = 10'h004;
    repeat (D - 1) step();
    enter = 1; step(); enter = 0;
    keypad = '0;
    n_checks++;
    if ({load, busy, input_signal, count, entry} !== {1'b1, 1'b1, 4'd0, 3'd1, 12'h002} ||
        {load, busy, input_signal, count, entry} !== m_vec())
      $display("FAIL digit_enter: got %h want %h", {load, busy, input_signal, count, entry}, m_vec());
    else n_pass++;
    repeat (2 * M) step();
    n_checks++;
    if (busy !== 0 || count !== 3'd0) $display("FAIL digit_enter_done: got busy %b count %0d want 0 0", busy, count);
    else n_pass++;
    repeat (D) step();
  endtask

  task automatic test_clear_mid();
    press(8);
    enter = 1; step(); enter = 0;
    repeat (2) step();
    clear = 1; step(); clear = 0;
    n_checks++;
    if ({load, busy, input_signal, count, entry} !== '0)
      $display("FAIL clear_mid: got %h want 0", {load, busy, input_signal, count, entry});
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic [9:0] cur, r10;
    int r;
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        r10 = 10'($urandom);
        case ($urandom_range(0, 4))
          0, 1:    cur = '0;
          2, 3:    cur = 10'(1) << $urandom_range(0, 9);
          default: cur = r10;
        endcase
      end
      r10 = 10'($urandom);
      keypad = (r >= 96) ? r10 : cur;
      if ($urandom_range(0, 99) < 4) enter = ~enter;
      if ($urandom_range(0, 199) < 2) cancel = ~cancel;
      clear = ($urandom_range(0, 999) < 2);
      step();
      n_checks++;
      if ({load, busy, input_signal, count, entry} !== m_vec())
        $display("FAIL random_c%0d: got %h want %h", c, {load, busy, input_signal, count, entry}, m_vec());
      else n_pass++;
    end
    clear = 0; enter = 0; cancel = 0; keypad = '0;
  endtask

  initial begin
    clear = 1; keypad = '0; enter = 0; cancel = 0;
    test_reset();
    test_debounce();
    test_entry_overflow();
    test_transfer();
    test_partial();
    test_cancel_mid();
    test_collision();
    test_clear_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
